lsu_mem_master: RTL and testbench

- Load/store unit between the MEM pipeline stage and the byte-addressed 64-bit data memory; it is the initiator that drives Mem_Addr, Write_Data, Mem_Read and Mem_Write.
- Supports RISC-V byte, half, word and doubleword loads and stores, with sign or zero extension on loads.
- Sub-doubleword stores use read-modify-write, because the memory always writes 8 bytes.
- Flags misaligned and out-of-range accesses instead of issuing them.

---
 rtl/lsu_mem_master.sv | 174 +++++++++++++++++
 tb/tb_lsu_mem_master.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store unit driving a byte-addressed 64-bit data memory.
// Sub-doubleword stores are done as read-modify-write because the memory always writes 8 bytes.
module lsu_mem_master #(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,
    output logic        done,
    output logic        err,
    output logic [63:0] load_data,
    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    output logic        Mem_Read,
    output logic        Mem_Write,
    input  logic [63:0] Read_Data
);

    localparam logic [63:0] LP_MAX_ADDR = 64'(MEM_BYTES - 32'd8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      r_state;
    logic        r_req_ready;
    logic        r_done;
    logic        r_err;
    logic [63:0] r_load_data;
    logic [63:0] r_mem_addr;
    logic [63:0] r_write_data;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [2:0]  r_funct3;
    logic [63:0] r_store_data;

    logic        w_misaligned;
    logic        w_req_err;
    logic [63:0] w_load_ext;
    logic [63:0] w_rmw_data;

    // Request screening on the live inputs, used only at the acceptance edge
    always_comb begin
        w_misaligned = 1'b0;
        case (funct3[1:0])
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = addr[0];
            2'd2:    w_misaligned = |addr[1:0];
            default: w_misaligned = |addr[2:0];
        endcase
        w_req_err = w_misaligned
                  | (addr > LP_MAX_ADDR)
                  | (funct3 == 3'b111)
                  | (req_store & funct3[2]);
    end

    // Load result extension from the latched size/sign code
    always_comb begin
        w_load_ext = Read_Data;
        case (r_funct3)
            3'b000:  w_load_ext = {{56{Read_Data[7]}},  Read_Data[7:0]};
            3'b001:  w_load_ext = {{48{Read_Data[15]}}, Read_Data[15:0]};
            3'b010:  w_load_ext = {{32{Read_Data[31]}}, Read_Data[31:0]};
            3'b100:  w_load_ext = {56'd0, Read_Data[7:0]};
            3'b101:  w_load_ext = {48'd0, Read_Data[15:0]};
            3'b110:  w_load_ext = {32'd0, Read_Data[31:0]};
            default: w_load_ext = Read_Data;
        endcase
    end

    // Store merge: low bytes from the store source, upper bytes kept from memory
    always_comb begin
        w_rmw_data = Read_Data;
        case (r_funct3[1:0])
            2'd0:    w_rmw_data = {Read_Data[63:8],  r_store_data[7:0]};
            2'd1:    w_rmw_data = {Read_Data[63:16], r_store_data[15:0]};
            2'd2:    w_rmw_data = {Read_Data[63:32], r_store_data[31:0]};
            default: w_rmw_data = r_store_data;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_load_data  <= 64'd0;
            r_mem_addr   <= 64'd0;
            r_write_data <= 64'd0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_funct3     <= 3'd0;
            r_store_data <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_ready  <= 1'b0;
                        r_mem_addr   <= addr;
                        r_funct3     <= funct3;
                        r_store_data <= store_data;
                        if (w_req_err) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_err       <= 1'b1;
                            r_load_data <= 64'd0;
                        end else if (!req_store) begin
                            r_state    <= S_LOAD;
                            r_mem_read <= 1'b1;
                        end else if (funct3[1:0] == 2'd3) begin
                            r_state      <= S_WRITE;
                            r_mem_write  <= 1'b1;
                            r_write_data <= store_data;
                        end else begin
                            r_state    <= S_RMW_RD;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_state     <= S_DONE;
                    r_mem_read  <= 1'b0;
                    r_done      <= 1'b1;
                    r_load_data <= w_load_ext;
                end
                S_RMW_RD: begin
                    r_state      <= S_WRITE;
                    r_mem_read   <= 1'b0;
                    r_mem_write  <= 1'b1;
                    r_write_data <= w_rmw_data;
                end
                S_WRITE: begin
                    r_state     <= S_DONE;
                    r_mem_write <= 1'b0;
                    r_done      <= 1'b1;
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign done       = r_done;
    assign err        = r_err;
    assign load_data  = r_load_data;
    assign Mem_Addr   = r_mem_addr;
    assign Write_Data = r_write_data;
    assign Mem_Read   = r_mem_read;
    assign Mem_Write  = r_mem_write;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a byte-array memory model.
module tb_lsu_mem_master;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic        done;
    logic        err;
    logic [63:0] load_data;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        Mem_Read;
    logic        Mem_Write;
    logic [63:0] Read_Data;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:263];
    logic [8:0] w_ra;

    lsu_mem_master #(.MEM_BYTES(256)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .done       (done),
        .err        (err),
        .load_data  (load_data),
        .Mem_Addr   (Mem_Addr),
        .Write_Data (Write_Data),
        .Mem_Read   (Mem_Read),
        .Mem_Write  (Mem_Write),
        .Read_Data  (Read_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign w_ra = {1'b0, Mem_Addr[7:0]};
    assign Read_Data = {mem[w_ra + 9'd7], mem[w_ra + 9'd6], mem[w_ra + 9'd5], mem[w_ra + 9'd4],
                        mem[w_ra + 9'd3], mem[w_ra + 9'd2], mem[w_ra + 9'd1], mem[w_ra]};

    always @(posedge clk) begin
        if (Mem_Write) begin
            for (int i = 0; i < 8; i++) mem[int'(Mem_Addr[7:0]) + i] = Write_Data[i*8 +: 8];
        end
    end

    function automatic logic [63:0] mem_dw(input int a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = mem[a + i];
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Issue one request, track latency and memory strobes, check completion and return to idle
    task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] d,
                           input int exp_lat, input logic exp_err,
                           output logic [63:0] ld);
        int   n;
        logic got;
        logic saw_acc;
        n = 0; got = 1'b0; saw_acc = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; funct3 = f3; addr = a; store_data = d;
        check_val({tag, "_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; addr = ~a; store_data = ~d;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (Mem_Read && Mem_Write) check_val({tag, "_rw_both"}, 64'd1, 64'd0);
            if (Mem_Read || Mem_Write) begin
                saw_acc = 1'b1;
                check_val({tag, "_maddr"}, Mem_Addr, a);
            end
            if (done) got = 1'b1;
            else @(posedge clk);
        end
        check_val({tag, "_done_seen"}, 64'(got), 64'd1);
        check_val({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check_val({tag, "_err"}, 64'(err), 64'(exp_err));
        if (exp_err) begin
            check_val({tag, "_no_access"}, 64'(saw_acc), 64'd0);
            check_val({tag, "_ld_zero"}, load_data, 64'd0);
        end
        ld = load_data;
        @(posedge clk);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
        check_val({tag, "_idle"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] ld;
        for (int i = 0; i < 264; i++) mem[i] = 8'h00;
        mem[0] = 8'd10; mem[8] = 8'd9; mem[16] = 8'h08; mem[24] = 8'h07;
        reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; funct3 = 3'd0;
        addr = 64'd0; store_data = 64'd0;
        repeat (2) @(negedge clk);
        check_val("rst_ready", 64'(req_ready), 64'd1);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_err", 64'(err), 64'd0);
        check_val("rst_rd", 64'(Mem_Read), 64'd0);
        check_val("rst_wr", 64'(Mem_Write), 64'd0);
        check_val("rst_ld", load_data, 64'd0);
        check_val("rst_maddr", Mem_Addr, 64'd0);
        check_val("rst_wdata", Write_Data, 64'd0);
        reset_n = 1'b1;

        run_req("ld8", 1'b0, 3'b011, 64'd8, 64'd0, 2, 1'b0, ld);
        check_val("ld8_val", ld, 64'd9);

        // Request held across two loads
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; funct3 = 3'b011; addr = 64'd8;
        check_val("b2b_ready0", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check_val("b2b_ready_load", 64'(req_ready), 64'd0);
        check_val("b2b_rd", 64'(Mem_Read), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check_val("b2b_done1", 64'(done), 64'd1);
        check_val("b2b_val1", load_data, 64'd9);
        check_val("b2b_ready_done", 64'(req_ready), 64'd0);
        addr = 64'd16;
        @(posedge clk);
        @(negedge clk);
        check_val("b2b_idle", 64'(req_ready), 64'd1);
        check_val("b2b_nodone", 64'(done), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("b2b_ready_load2", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("b2b_done2", 64'(done), 64'd1);
        check_val("b2b_val2", load_data, 64'd8);
        @(posedge clk);

        run_req("sb16", 1'b1, 3'b000, 64'd16, 64'h1234_56AB, 3, 1'b0, ld);
        check_val("sb16_mem", mem_dw(16), 64'h0000_0000_0000_00AB);
        run_req("lb16", 1'b0, 3'b000, 64'd16, 64'd0, 2, 1'b0, ld);
        check_val("lb16_val", ld, 64'hFFFF_FFFF_FFFF_FFAB);
        run_req("lbu16", 1'b0, 3'b100, 64'd16, 64'd0, 2, 1'b0, ld);
        check_val("lbu16_val", ld, 64'h0000_0000_0000_00AB);

        run_req("sw24", 1'b1, 3'b010, 64'd24, 64'hDEAD_BEEF, 3, 1'b0, ld);
        check_val("sw24_mem", mem_dw(24), 64'h0000_0000_DEAD_BEEF);
        run_req("lw24", 1'b0, 3'b010, 64'd24, 64'd0, 2, 1'b0, ld);
        check_val("lw24_val", ld, 64'hFFFF_FFFF_DEAD_BEEF);
        run_req("lwu24", 1'b0, 3'b110, 64'd24, 64'd0, 2, 1'b0, ld);
        check_val("lwu24_val", ld, 64'h0000_0000_DEAD_BEEF);

        run_req("sh32", 1'b1, 3'b001, 64'd32, 64'h0000_8001, 3, 1'b0, ld);
        run_req("lh32", 1'b0, 3'b001, 64'd32, 64'd0, 2, 1'b0, ld);
        check_val("lh32_val", ld, 64'hFFFF_FFFF_FFFF_8001);

        run_req("sd40", 1'b1, 3'b011, 64'd40, 64'h0102_0304_0506_0708, 2, 1'b0, ld);
        check_val("sd40_mem", mem_dw(40), 64'h0102_0304_0506_0708);

        run_req("err_lw_mis", 1'b0, 3'b010, 64'd2, 64'd0, 1, 1'b1, ld);
        run_req("lwu24b", 1'b0, 3'b110, 64'd24, 64'd0, 2, 1'b0, ld);
        run_req("err_ld_range", 1'b0, 3'b011, 64'd252, 64'd0, 1, 1'b1, ld);
        run_req("ld248", 1'b0, 3'b011, 64'd248, 64'd0, 2, 1'b0, ld);
        check_val("ld248_val", ld, 64'd0);
        run_req("ld24c", 1'b0, 3'b011, 64'd24, 64'd0, 2, 1'b0, ld);
        run_req("err_f3_111", 1'b0, 3'b111, 64'd8, 64'd0, 1, 1'b1, ld);
        run_req("ld24d", 1'b0, 3'b011, 64'd24, 64'd0, 2, 1'b0, ld);
        run_req("err_sbu", 1'b1, 3'b100, 64'd16, 64'hFF, 1, 1'b1, ld);
        check_val("err_sbu_mem", mem_dw(16), 64'h0000_0000_0000_00AB);

        // Reset dropped while the doubleword store is in WRITE
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; funct3 = 3'b011; addr = 64'd0; store_data = 64'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_val("rst_mid_wr_before", 64'(Mem_Write), 64'd1);
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_wr_after", 64'(Mem_Write), 64'd0);
        check_val("rst_mid_ready", 64'(req_ready), 64'd1);
        check_val("rst_mid_done", 64'(done), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_mid_nodone", 64'(done), 64'd0);
        end
        check_val("rst_mid_mem", mem_dw(0), 64'd10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
